// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch/decode/issue sequencer.
// The state encoding and halt opcode live here so the sequencer and its neighbours agree.
package fetch_sequencer_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam int          PRED_CNT_DEF = 64;
  localparam int          INSTR_W      = 64;
  localparam int          SQUASH_W     = 16;
  localparam logic [7:0]  OP_HALT_DEF  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EVAL,
    ST_ISSUE,
    ST_HALT
  } state_e;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [SQUASH_W-1:0] sat_inc(input logic [SQUASH_W-1:0] v);
    return (v == {SQUASH_W{1'b1}}) ? v : v + SQUASH_W'(1);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Sequences one instruction at a time through fetch, decode, predicate screening and issue.
// Owns the PC; every output is a flop decoded from the next state.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter int         PRED_CNT = PRED_CNT_DEF,
  parameter logic [7:0] OP_HALT  = OP_HALT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   pc_start,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                mem_ready,
  output logic                decode_enable,
  output logic [INSTR_W-1:0]  instruction_data,
  input  logic [7:0]          opcode,
  input  logic [5:0]          predicate,
  input  logic [PRED_CNT-1:0] pred_file,
  output logic                issue_valid,
  input  logic                issue_ready,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                busy,
  output logic                halted,
  output logic [SQUASH_W-1:0] squash_count
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;
  logic [SQUASH_W-1:0]   squash_q, squash_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  decode_enable_q, decode_enable_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic [ADDR_W-1:0]     pc_inc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    squash_d  = squash_q;
    pc_inc    = pc_q + ADDR_W'(1);

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = pc_start;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) pc_d    = redirect_pc;
        else                state_d = ST_WAIT;
      end
      // A live request is never abandoned: a redirect only marks its reply for dropping.
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (mem_ready) begin
            discard_d = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            discard_d = 1'b1;
          end
        end else if (mem_ready) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            instr_d = mem_rdata;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else if (!pred_file[predicate]) begin
          squash_d = sat_inc(squash_q);
          pc_d     = pc_inc;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      // A same-cycle handshake still retires the instruction, but the redirect target wins.
      ST_ISSUE: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (issue_ready) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mem_req_d       = (state_d == ST_FETCH) || (state_d == ST_WAIT);
    mem_addr_d      = mem_req_d ? pc_d : '0;
    decode_enable_d = (state_d == ST_DECODE);
    issue_valid_d   = (state_d == ST_ISSUE);
    halted_d        = (state_d == ST_HALT);
    busy_d          = !((state_d == ST_IDLE) || (state_d == ST_HALT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pc_q            <= '0;
      discard_q       <= 1'b0;
      instr_q         <= '0;
      squash_q        <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      decode_enable_q <= 1'b0;
      issue_valid_q   <= 1'b0;
      busy_q          <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      discard_q       <= discard_d;
      instr_q         <= instr_d;
      squash_q        <= squash_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      decode_enable_q <= decode_enable_d;
      issue_valid_q   <= issue_valid_d;
      busy_q          <= busy_d;
      halted_q        <= halted_d;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;
  assign decode_enable    = decode_enable_q;
  assign instruction_data = instr_q;
  assign issue_valid      = issue_valid_q;
  assign pc_out           = pc_q;
  assign busy             = busy_q;
  assign halted           = halted_q;
  assign squash_count     = squash_q;

endmodule
